// File: rtl/dd_pkg.sv
// -----------------------------------------------------------------------------
// dd_pkg
// Shared constants for the 64DD request queue slice.
//   DD_CMD_W / DD_DATA_W : default command and data/status field widths
//   DD_CH_CMD / DD_CH_BM : channel indices of the drive-command and
//                          buffer-manager request sources
//   dd_ch_width()        : channel tag width, at least one bit so that a
//                          single-channel build still has a legal vector
// -----------------------------------------------------------------------------
package dd_pkg;

    localparam int DD_CMD_W  = 8;
    localparam int DD_DATA_W = 16;

    localparam int DD_CH_CMD = 0;
    localparam int DD_CH_BM  = 1;

    function automatic int dd_ch_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/dd_rr_arbiter.sv
// -----------------------------------------------------------------------------
// dd_rr_arbiter
// Round-robin arbiter selecting at most one requester per cycle.
//   clk, reset  : clock, async active-high reset (pointer returns to 0)
//   req         : per-channel request vector
//   enable      : when low no grant is issued
//   advance     : a grant was consumed; pointer moves past the winner
//   grant       : one-hot grant (combinational)
//   grant_idx   : binary index of the granted channel (0 when no grant)
// -----------------------------------------------------------------------------
module dd_rr_arbiter
    import dd_pkg::*;
#(
    parameter int  CHANNELS = 2,
    localparam int CH_W     = dd_ch_width(CHANNELS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] req,
    input  logic                enable,
    input  logic                advance,
    output logic [CHANNELS-1:0] grant,
    output logic [CH_W-1:0]     grant_idx
);

    logic [CH_W-1:0] ptr;
    logic            found;
    int              scan_idx;

    // Scan channels starting at the pointer and wrapping; the first active
    // request wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        scan_idx  = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            scan_idx = (int'(ptr) + i) % CHANNELS;
            if (enable && !found && req[scan_idx]) begin
                found           = 1'b1;
                grant[scan_idx] = 1'b1;
                grant_idx       = CH_W'(scan_idx);
            end
        end
    end

    // The pointer only moves when a grant is actually taken, landing one
    // past the winner so that channel gets lowest priority next time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (grant_idx == CH_W'(CHANNELS - 1)) ? '0 : grant_idx + CH_W'(1);
        end
    end

endmodule

// File: rtl/dd_request_queue.sv
// -----------------------------------------------------------------------------
// dd_request_queue
// 64DD command / buffer-manager request queue between N64-side register logic
// and the CPU. Requests from CHANNELS sources are round-robin arbitrated into
// one in-order FIFO; the CPU pops the head and its response is routed back to
// the channel that issued the request.
//   clk, reset            : clock, async active-high reset
//   hard_reset            : N64 hard reset, synchronous flush of the queue
//   req_valid/req_ready   : per-channel request handshake (ready is one-hot)
//   req_command/req_data  : per-channel request payload, packed
//   rsp_valid             : one-cycle response pulse to originating channel
//   rsp_status/rsp_data   : shared response payload, qualified by rsp_valid
//   cpu_valid/channel/
//   command/data          : registered queue head
//   cpu_ack               : pop head, carries cpu_status / cpu_rsp_data
//   occupancy             : number of entries held, 0..DEPTH
// -----------------------------------------------------------------------------
module dd_request_queue
    import dd_pkg::*;
#(
    parameter int  CHANNELS = 2,
    parameter int  DEPTH    = 4,
    parameter int  CMD_W    = DD_CMD_W,
    parameter int  DATA_W   = DD_DATA_W,
    localparam int CH_W     = dd_ch_width(CHANNELS),
    localparam int AW       = $clog2(DEPTH),
    localparam int OCC_W    = $clog2(DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       hard_reset,
    input  logic [CHANNELS-1:0]        req_valid,
    output logic [CHANNELS-1:0]        req_ready,
    input  logic [CHANNELS*CMD_W-1:0]  req_command,
    input  logic [CHANNELS*DATA_W-1:0] req_data,
    output logic [CHANNELS-1:0]        rsp_valid,
    output logic [DATA_W-1:0]          rsp_status,
    output logic [DATA_W-1:0]          rsp_data,
    output logic                       cpu_valid,
    output logic [CH_W-1:0]            cpu_channel,
    output logic [CMD_W-1:0]           cpu_command,
    output logic [DATA_W-1:0]          cpu_data,
    input  logic                       cpu_ack,
    input  logic [DATA_W-1:0]          cpu_status,
    input  logic [DATA_W-1:0]          cpu_rsp_data,
    output logic [OCC_W-1:0]           occupancy
);

    logic [CH_W-1:0]     tag_mem  [DEPTH];
    logic [CMD_W-1:0]    cmd_mem  [DEPTH];
    logic [DATA_W-1:0]   data_mem [DEPTH];

    logic [AW-1:0]       wr_idx;
    logic [AW-1:0]       rd_idx;
    logic [AW-1:0]       rd_idx_next;
    logic [OCC_W-1:0]    occ_next;

    logic [CHANNELS-1:0] grant;
    logic [CH_W-1:0]     grant_idx;
    logic                arb_enable;
    logic                push;
    logic                pop;
    logic [CMD_W-1:0]    push_cmd;
    logic [DATA_W-1:0]   push_data;

    // No bypass: a full queue refuses pushes even if the head pops this cycle.
    assign arb_enable = (occupancy < OCC_W'(DEPTH)) && !hard_reset;
    assign req_ready  = grant;
    assign push       = |grant;
    assign pop        = cpu_ack && cpu_valid && !hard_reset;

    assign push_cmd   = req_command[int'(grant_idx)*CMD_W +: CMD_W];
    assign push_data  = req_data[int'(grant_idx)*DATA_W +: DATA_W];

    assign occ_next    = occupancy + OCC_W'(push) - OCC_W'(pop);
    assign rd_idx_next = rd_idx + AW'(pop);

    dd_rr_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_arbiter (
        .clk       (clk),
        .reset     (reset),
        .req       (req_valid),
        .enable    (arb_enable),
        .advance   (push),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Entry storage; contents need no reset since occupancy guards reads.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_idx]  <= grant_idx;
            cmd_mem[wr_idx]  <= push_cmd;
            data_mem[wr_idx] <= push_data;
        end
    end

    // Indices, occupancy and the registered head. When the queue will hold
    // only the entry being pushed this cycle, the head is loaded straight
    // from the request so it appears one cycle after the push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_idx      <= '0;
            rd_idx      <= '0;
            occupancy   <= '0;
            cpu_valid   <= 1'b0;
            cpu_channel <= '0;
            cpu_command <= '0;
            cpu_data    <= '0;
        end else if (hard_reset) begin
            wr_idx      <= '0;
            rd_idx      <= '0;
            occupancy   <= '0;
            cpu_valid   <= 1'b0;
        end else begin
            if (push) begin
                wr_idx <= wr_idx + AW'(1);
            end
            rd_idx    <= rd_idx_next;
            occupancy <= occ_next;
            cpu_valid <= (occ_next != '0);
            if (occupancy == OCC_W'(pop)) begin
                if (push) begin
                    cpu_channel <= grant_idx;
                    cpu_command <= push_cmd;
                    cpu_data    <= push_data;
                end
            end else begin
                cpu_channel <= tag_mem[rd_idx_next];
                cpu_command <= cmd_mem[rd_idx_next];
                cpu_data    <= data_mem[rd_idx_next];
            end
        end
    end

    // Response path: a pop returns the CPU's status/data to the channel that
    // owned the popped head, as a single-cycle pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid  <= '0;
            rsp_status <= '0;
            rsp_data   <= '0;
        end else if (pop) begin
            rsp_valid  <= CHANNELS'(1) << cpu_channel;
            rsp_status <= cpu_status;
            rsp_data   <= cpu_rsp_data;
        end else begin
            rsp_valid  <= '0;
        end
    end

endmodule

// File: tb/tb_dd_request_queue.sv
// -----------------------------------------------------------------------------
// tb_dd_request_queue
// Directed bench for dd_request_queue (CHANNELS=2, DEPTH=4). Expected head
// entries are queued when a grant is expected; expected responses are queued
// when the head is acked and popped when the response pulse is due.
// -----------------------------------------------------------------------------
module tb_dd_request_queue;

    localparam int CHANNELS = 2;
    localparam int DEPTH    = 4;
    localparam int CMD_W    = 8;
    localparam int DATA_W   = 16;
    localparam int CH_W     = 1;
    localparam int OCC_W    = 3;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       hard_reset;
    logic [CHANNELS-1:0]        req_valid;
    logic [CHANNELS-1:0]        req_ready;
    logic [CHANNELS*CMD_W-1:0]  req_command;
    logic [CHANNELS*DATA_W-1:0] req_data;
    logic [CHANNELS-1:0]        rsp_valid;
    logic [DATA_W-1:0]          rsp_status;
    logic [DATA_W-1:0]          rsp_data;
    logic                       cpu_valid;
    logic [CH_W-1:0]            cpu_channel;
    logic [CMD_W-1:0]           cpu_command;
    logic [DATA_W-1:0]          cpu_data;
    logic                       cpu_ack;
    logic [DATA_W-1:0]          cpu_status;
    logic [DATA_W-1:0]          cpu_rsp_data;
    logic [OCC_W-1:0]           occupancy;

    typedef struct {
        int          ch;
        logic [7:0]  cmd;
        logic [15:0] data;
    } head_t;

    typedef struct {
        int          ch;
        logic [15:0] status;
        logic [15:0] data;
    } rsp_t;

    head_t expHead[$];
    rsp_t  expRsp[$];
    int    vectors     = 0;
    int    miscompares = 0;

    always #5 clk = ~clk;

    dd_request_queue #(
        .CHANNELS (CHANNELS),
        .DEPTH    (DEPTH),
        .CMD_W    (CMD_W),
        .DATA_W   (DATA_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .hard_reset   (hard_reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_command  (req_command),
        .req_data     (req_data),
        .rsp_valid    (rsp_valid),
        .rsp_status   (rsp_status),
        .rsp_data     (rsp_data),
        .cpu_valid    (cpu_valid),
        .cpu_channel  (cpu_channel),
        .cpu_command  (cpu_command),
        .cpu_data     (cpu_data),
        .cpu_ack      (cpu_ack),
        .cpu_status   (cpu_status),
        .cpu_rsp_data (cpu_rsp_data),
        .occupancy    (occupancy)
    );

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic [7:0] cmd0, input logic [15:0] d0,
                                 input logic [7:0] cmd1, input logic [15:0] d1);
        req_valid   = valid;
        req_command = {cmd1, cmd0};
        req_data    = {d1, d0};
    endtask

    // Check the combinational accept vector; ch < 0 means no grant expected.
    task automatic expectGrant(input string tag, input int ch);
        head_t h;
        #1;
        checkOutput(tag, 32'(req_ready), (ch < 0) ? 32'd0 : 32'(1 << ch));
        if (ch >= 0) begin
            h.ch   = ch;
            h.cmd  = req_command[ch*8 +: 8];
            h.data = req_data[ch*16 +: 16];
            expHead.push_back(h);
        end
    endtask

    task automatic ackHead(input logic [15:0] status, input logic [15:0] rdata);
        head_t h;
        rsp_t  r;
        cpu_ack      = 1'b1;
        cpu_status   = status;
        cpu_rsp_data = rdata;
        if (expHead.size() > 0) begin
            h        = expHead.pop_front();
            r.ch     = h.ch;
            r.status = status;
            r.data   = rdata;
            expRsp.push_back(r);
        end
    endtask

    task automatic checkHead(input string tag);
        if (expHead.size() == 0) begin
            checkOutput({tag, ".valid"}, 32'(cpu_valid), 32'd0);
        end else begin
            checkOutput({tag, ".valid"},   32'(cpu_valid),   32'd1);
            checkOutput({tag, ".channel"}, 32'(cpu_channel), 32'(expHead[0].ch));
            checkOutput({tag, ".command"}, 32'(cpu_command), 32'(expHead[0].cmd));
            checkOutput({tag, ".data"},    32'(cpu_data),    32'(expHead[0].data));
        end
    endtask

    task automatic checkRsp(input string tag, input bit expectRsp);
        rsp_t r;
        if (!expectRsp) begin
            checkOutput({tag, ".valid"}, 32'(rsp_valid), 32'd0);
        end else if (expRsp.size() == 0) begin
            checkOutput({tag, ".scoreboard"}, 32'(expRsp.size()), 32'd1);
        end else begin
            r = expRsp.pop_front();
            checkOutput({tag, ".valid"},  32'(rsp_valid),  32'(1 << r.ch));
            checkOutput({tag, ".status"}, 32'(rsp_status), 32'(r.status));
            checkOutput({tag, ".data"},   32'(rsp_data),   32'(r.data));
        end
    endtask

    task automatic checkOcc(input string tag, input int exp);
        checkOutput(tag, 32'(occupancy), 32'(exp));
    endtask

    initial begin
        reset        = 1'b1;
        hard_reset   = 1'b0;
        req_valid    = '0;
        req_command  = '0;
        req_data     = '0;
        cpu_ack      = 1'b0;
        cpu_status   = '0;
        cpu_rsp_data = '0;

        tick();
        tick();
        checkOutput("reset.cpu_valid", 32'(cpu_valid), 32'd0);
        checkOutput("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        checkOcc("reset.occupancy", 0);
        checkOutput("reset.req_ready", 32'(req_ready), 32'd0);
        reset = 1'b0;

        // Single ch0 request, then ack it.
        applyStimulus(2'b01, 8'h08, 16'h1234, 8'h00, 16'h0000);
        expectGrant("t1.grant", 0);
        tick();
        applyStimulus(2'b00, 8'h00, 16'h0000, 8'h00, 16'h0000);
        checkHead("t1.head");
        checkOcc("t1.occ", 1);
        ackHead(16'h0040, 16'hBEEF);
        tick();
        cpu_ack = 1'b0;
        checkRsp("t1.rsp", 1);
        checkOcc("t1.occ_after", 0);
        checkHead("t1.empty");
        tick();
        checkRsp("t1.rsp_clear", 0);

        // Single ch1 request routes its response to ch1 and realigns the pointer.
        applyStimulus(2'b10, 8'h00, 16'h0000, 8'h21, 16'hA1A1);
        expectGrant("t1b.grant", 1);
        tick();
        applyStimulus(2'b00, 8'h00, 16'h0000, 8'h00, 16'h0000);
        checkHead("t1b.head");
        ackHead(16'h0041, 16'h5555);
        tick();
        cpu_ack = 1'b0;
        checkRsp("t1b.rsp", 1);

        // Both channels contend for four cycles: grants alternate 0,1,0,1.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b11, 8'(48 + i), 16'(16'h3000 + i), 8'(64 + i), 16'(16'h4000 + i));
            expectGrant($sformatf("t2.grant%0d", i), i % 2);
            tick();
            checkOcc($sformatf("t2.occ%0d", i), i + 1);
            checkHead($sformatf("t2.head%0d", i));
        end

        // Full: no accept, not even while the head pops.
        expectGrant("t3.full", -1);
        checkOcc("t3.occ_full", 4);
        ackHead(16'h0077, 16'h7777);
        expectGrant("t3.nobypass", -1);
        tick();
        cpu_ack = 1'b0;
        checkRsp("t3.rsp", 1);
        checkOcc("t3.occ_popped", 3);
        expectGrant("t3.ready_after_pop", 0);
        tick();
        applyStimulus(2'b00, 8'h00, 16'h0000, 8'h00, 16'h0000);
        checkOcc("t3.occ_refill", 4);
        checkHead("t3.head");

        for (int i = 0; i < 2; i++) begin
            ackHead(16'(16'h0100 + i), 16'(16'h0200 + i));
            tick();
            checkRsp($sformatf("t3.drain%0d", i), 1);
            checkHead($sformatf("t3.drain_head%0d", i));
        end
        cpu_ack = 1'b0;
        checkOcc("t3.occ_two", 2);

        // Push and pop together keep occupancy and order.
        applyStimulus(2'b11, 8'h50, 16'h5000, 8'h51, 16'h5001);
        ackHead(16'h0300, 16'h0301);
        expectGrant("t4.grant_a", 1);
        tick();
        checkRsp("t4.rsp_a", 1);
        checkOcc("t4.occ_a", 2);
        checkHead("t4.head_a");
        applyStimulus(2'b11, 8'h60, 16'h6000, 8'h61, 16'h6001);
        ackHead(16'h0310, 16'h0311);
        expectGrant("t4.grant_b", 0);
        tick();
        applyStimulus(2'b00, 8'h00, 16'h0000, 8'h00, 16'h0000);
        checkRsp("t4.rsp_b", 1);
        checkOcc("t4.occ_b", 2);
        checkHead("t4.head_b");
        for (int i = 0; i < 2; i++) begin
            ackHead(16'(16'h0400 + i), 16'(16'h0500 + i));
            tick();
            checkRsp($sformatf("t4.drain%0d", i), 1);
            checkHead($sformatf("t4.drain_head%0d", i));
        end
        cpu_ack = 1'b0;
        checkOcc("t4.occ_empty", 0);

        // Hard reset with three entries and a same-cycle push and ack.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b01, 8'(112 + i), 16'(16'h7000 + i), 8'h00, 16'h0000);
            expectGrant($sformatf("t5.fill%0d", i), 0);
            tick();
        end
        applyStimulus(2'b00, 8'h00, 16'h0000, 8'h00, 16'h0000);
        checkOcc("t5.occ_three", 3);
        hard_reset = 1'b1;
        applyStimulus(2'b11, 8'h80, 16'h8000, 8'h81, 16'h8001);
        cpu_ack    = 1'b1;
        cpu_status = 16'h0999;
        expectGrant("t5.hr_ready", -1);
        tick();
        hard_reset = 1'b0;
        cpu_ack    = 1'b0;
        applyStimulus(2'b00, 8'h00, 16'h0000, 8'h00, 16'h0000);
        expHead.delete();
        checkOcc("t5.occ_flushed", 0);
        checkHead("t5.head_flushed");
        checkRsp("t5.no_rsp", 0);
        applyStimulus(2'b11, 8'h90, 16'h9000, 8'h91, 16'h9001);
        expectGrant("t5.ptr_kept", 1);
        tick();
        applyStimulus(2'b00, 8'h00, 16'h0000, 8'h00, 16'h0000);
        checkOcc("t5.occ_one", 1);
        checkHead("t5.head_after");

        // Async reset mid-stream.
        applyStimulus(2'b01, 8'hA0, 16'hA000, 8'h00, 16'h0000);
        expectGrant("t6.grant", 0);
        tick();
        applyStimulus(2'b00, 8'h00, 16'h0000, 8'h00, 16'h0000);
        checkOcc("t6.occ_two", 2);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t6.cpu_valid",   32'(cpu_valid),   32'd0);
        checkOutput("t6.cpu_channel", 32'(cpu_channel), 32'd0);
        checkOutput("t6.cpu_command", 32'(cpu_command), 32'd0);
        checkOutput("t6.cpu_data",    32'(cpu_data),    32'd0);
        checkOutput("t6.rsp_status",  32'(rsp_status),  32'd0);
        checkOutput("t6.rsp_data",    32'(rsp_data),    32'd0);
        checkOcc("t6.occupancy", 0);
        expHead.delete();
        expRsp.delete();
        tick();
        reset = 1'b0;
        applyStimulus(2'b11, 8'hB0, 16'hB000, 8'hB1, 16'hB001);
        expectGrant("t6.post_reset_grant", 0);
        tick();
        applyStimulus(2'b00, 8'h00, 16'h0000, 8'h00, 16'h0000);
        checkHead("t6.post_reset_head");
        checkOcc("t6.post_reset_occ", 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
